// File: rtl/iccm_boot_pkg.sv
`default_nettype none
// ============================================================================
// Package     : iccm_boot_pkg
// Description : Shared types and constants for the ICCM boot loader.
// Revision    : 1.0 - initial release
// ============================================================================
package iccm_boot_pkg;

  // Loader FSM states
  typedef enum logic [1:0] {
    StLoad  = 2'd0,
    StDone  = 2'd1,
    StError = 2'd2
  } boot_state_e;

  // Default end-of-program marker; this word is never written to the ICCM
  localparam logic [31:0] EndWordDefault = 32'h0000_0FFF;

endpackage
`default_nettype wire

// File: rtl/iccm_byte_assembler.sv
`default_nettype none
// ============================================================================
// Module      : iccm_byte_assembler
// Description : Packs a little-endian byte stream into 32-bit words. A
//               partial word is dropped after TimeoutCyc idle cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module iccm_byte_assembler #(
  parameter int unsigned TimeoutCyc = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        enable_i,
  input  logic [7:0]  rx_byte_i,
  input  logic        rx_valid_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  localparam int unsigned TW = $clog2(TimeoutCyc + 1);

  // Bytes 0..2 of the word in progress; byte 3 comes straight from the input
  logic [23:0]   shift_q;
  logic [1:0]    byte_cnt_q;
  logic [TW-1:0] idle_q;
  logic          take;

  assign take         = enable_i & rx_valid_i & ~clear_i;
  assign word_o       = {rx_byte_i, shift_q};
  assign word_valid_o = take & (byte_cnt_q == 2'd3);

  // Shift in bytes, count position in word, and expire stale partial words
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q    <= 24'd0;
      byte_cnt_q <= 2'd0;
      idle_q     <= '0;
    end else if (clear_i) begin
      byte_cnt_q <= 2'd0;
      idle_q     <= '0;
    end else if (take) begin
      shift_q    <= {rx_byte_i, shift_q[23:8]};
      byte_cnt_q <= byte_cnt_q + 2'd1;
      idle_q     <= '0;
    end else if (enable_i && byte_cnt_q != 2'd0) begin
      if (idle_q == TW'(TimeoutCyc - 1)) begin
        byte_cnt_q <= 2'd0;
        idle_q     <= '0;
      end else begin
        idle_q <= idle_q + TW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/iccm_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : iccm_boot_loader
// Description : Writes an assembled UART byte stream sequentially into the
//               ICCM and holds the core in load mode until the terminator.
// Revision    : 1.0 - initial release
// ============================================================================
module iccm_boot_loader
  import iccm_boot_pkg::*;
#(
  parameter int unsigned AddrW      = 12,
  parameter logic [31:0] EndWord    = EndWordDefault,
  parameter int unsigned TimeoutCyc = 1024
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [7:0]       rx_byte_i,
  input  logic             rx_valid_i,
  output logic [AddrW-1:0] iccm_cntrl_addr_o,
  output logic [31:0]      iccm_cntrl_data_o,
  output logic             iccm_cntrl_we_o,
  output logic             iccm_cntrl_reset_o,
  output logic             load_done_o,
  output logic             load_err_o,
  output logic [AddrW:0]   word_cnt_o
);

  localparam int unsigned CntW = AddrW + 1;

  logic [1:0]       rst_sync_q;
  logic             rst_n;
  boot_state_e      state_q;
  logic [AddrW-1:0] addr_q;
  logic [CntW-1:0]  word_cnt_q;
  logic             full_q;
  logic [31:0]      data_q;
  logic             we_q;
  logic             cntrl_reset_q;
  logic             done_q;
  logic             err_q;
  logic [31:0]      word;
  logic             word_valid;

  // Reset asserts immediately but is released on a clock edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rst_sync_q <= 2'b00;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  iccm_byte_assembler #(
    .TimeoutCyc (TimeoutCyc)
  ) u_asm (
    .clk_i        (clk_i),
    .rst_ni       (rst_n),
    .clear_i      (start_i),
    .enable_i     (state_q == StLoad),
    .rx_byte_i    (rx_byte_i),
    .rx_valid_i   (rx_valid_i),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  // Loader FSM with address/word counters and registered ICCM outputs
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StLoad;
      addr_q        <= '0;
      word_cnt_q    <= '0;
      full_q        <= 1'b0;
      data_q        <= 32'd0;
      we_q          <= 1'b0;
      cntrl_reset_q <= 1'b1;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (start_i) begin
        // Restart wins over any byte or pending address bump this cycle
        state_q       <= StLoad;
        addr_q        <= '0;
        word_cnt_q    <= '0;
        full_q        <= 1'b0;
        cntrl_reset_q <= 1'b1;
        done_q        <= 1'b0;
        err_q         <= 1'b0;
      end else begin
        // Advance address after the write cycle; the last slot marks memory full
        if (we_q) begin
          addr_q     <= addr_q + AddrW'(1);
          word_cnt_q <= word_cnt_q + CntW'(1);
          if (addr_q == '1) full_q <= 1'b1;
        end
        case (state_q)
          StLoad: begin
            if (word_valid) begin
              if (word == EndWord) begin
                state_q       <= StDone;
                done_q        <= 1'b1;
                cntrl_reset_q <= 1'b0;
              end else if (!full_q) begin
                we_q   <= 1'b1;
                data_q <= word;
              end else begin
                state_q <= StError;
                err_q   <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign iccm_cntrl_addr_o  = addr_q;
  assign iccm_cntrl_data_o  = data_q;
  assign iccm_cntrl_we_o    = we_q;
  assign iccm_cntrl_reset_o = cntrl_reset_q;
  assign load_done_o        = done_q;
  assign load_err_o         = err_q;
  assign word_cnt_o         = word_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_iccm_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_iccm_boot_loader
// Description : Self-checking bench for iccm_boot_loader (default geometry
//               plus a 4-word instance for the overflow path).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iccm_boot_loader;

  localparam int TO_A = 1024;
  localparam int TO_B = 8;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        start_a, valid_a;
  logic [7:0]  byte_a;
  logic [11:0] addr_a;
  logic [31:0] data_a;
  logic        we_a, cr_a, done_a, err_a;
  logic [12:0] wc_a;

  logic        start_b, valid_b;
  logic [7:0]  byte_b;
  logic [1:0]  addr_b;
  logic [31:0] data_b;
  logic        we_b, cr_b, done_b, err_b;
  logic [2:0]  wc_b;

  int total = 0;
  int bad   = 0;
  wr_t q_a[$];
  wr_t q_b[$];
  logic prev_we_a = 1'b0;
  logic prev_we_b = 1'b0;

  iccm_boot_loader #(.AddrW(12), .EndWord(32'h0000_0FFF), .TimeoutCyc(TO_A)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .rx_byte_i(byte_a), .rx_valid_i(valid_a),
    .iccm_cntrl_addr_o(addr_a), .iccm_cntrl_data_o(data_a), .iccm_cntrl_we_o(we_a),
    .iccm_cntrl_reset_o(cr_a), .load_done_o(done_a), .load_err_o(err_a), .word_cnt_o(wc_a)
  );

  iccm_boot_loader #(.AddrW(2), .EndWord(32'h0000_0FFF), .TimeoutCyc(TO_B)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .rx_byte_i(byte_b), .rx_valid_i(valid_b),
    .iccm_cntrl_addr_o(addr_b), .iccm_cntrl_data_o(data_b), .iccm_cntrl_we_o(we_b),
    .iccm_cntrl_reset_o(cr_b), .load_done_o(done_b), .load_err_o(err_b), .word_cnt_o(wc_b)
  );

  // Write monitor: every write strobe is matched against the scoreboard
  always @(negedge clk) begin
    wr_t e;
    if (we_a) begin
      total++;
      if (q_a.size() == 0) begin
        bad++;
        $display("FAIL wr_a: unexpected write addr=%h data=%h, required no write", addr_a, data_a);
      end else begin
        e = q_a.pop_front();
        if ({addr_a, data_a} !== e) begin
          bad++;
          $display("FAIL wr_a: got addr=%h data=%h, required addr=%h data=%h", addr_a, data_a, e.addr, e.data);
        end
      end
      total++;
      if (prev_we_a) begin
        bad++;
        $display("FAIL we_a_consec: got we in two consecutive cycles, required isolated pulses");
      end
    end
    if (we_b) begin
      total++;
      if (q_b.size() == 0) begin
        bad++;
        $display("FAIL wr_b: unexpected write addr=%h data=%h, required no write", addr_b, data_b);
      end else begin
        e = q_b.pop_front();
        if ({10'd0, addr_b, data_b} !== e) begin
          bad++;
          $display("FAIL wr_b: got addr=%h data=%h, required addr=%h data=%h", addr_b, data_b, e.addr, e.data);
        end
      end
    end
    prev_we_a = we_a;
    prev_we_b = we_b;
  end

  task automatic send_a(input logic [7:0] b);
    byte_a = b; valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
  endtask

  task automatic send_word_a(input logic [31:0] w);
    send_a(w[7:0]); send_a(w[15:8]); send_a(w[23:16]); send_a(w[31:24]);
  endtask

  task automatic send_word_b(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      byte_b = w[8*i +: 8]; valid_b = 1'b1;
      @(negedge clk);
    end
    valid_b = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 20 && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge clk);
    total++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: pending writes a=%0d b=%0d, required 0", name, q_a.size(), q_b.size());
      q_a.delete(); q_b.delete();
    end
  endtask

  task automatic pulse_start_a;
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
  endtask

  task automatic pulse_start_b;
    start_b = 1'b1; @(negedge clk); start_b = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start_a = 0; valid_a = 0; byte_a = 0;
    start_b = 0; valid_b = 0; byte_b = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({addr_a, data_a, we_a, cr_a, done_a, err_a, wc_a} !== {12'd0, 32'd0, 4'b0100, 13'd0}) begin
      bad++;
      $display("FAIL reset_a: got addr=%h data=%h we=%b cr=%b done=%b err=%b wc=%0d, required 0/0/0/1/0/0/0",
               addr_a, data_a, we_a, cr_a, done_a, err_a, wc_a);
    end
    total++;
    if ({addr_b, data_b, we_b, cr_b, done_b, err_b, wc_b} !== {2'd0, 32'd0, 4'b0100, 3'd0}) begin
      bad++;
      $display("FAIL reset_b: got addr=%h we=%b cr=%b done=%b err=%b wc=%0d, required 0/0/1/0/0/0",
               addr_b, we_b, cr_b, done_b, err_b, wc_b);
    end
  endtask

  task automatic test_back_to_back;
    q_a.push_back('{addr: 12'd0, data: 32'h0000_0013});
    q_a.push_back('{addr: 12'd1, data: 32'hDEAD_BEEF});
    send_word_a(32'h0000_0013);
    send_word_a(32'hDEAD_BEEF);
    drain("b2b");
    total++;
    if ({wc_a, cr_a, done_a} !== {13'd2, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL b2b_state: got wc=%0d cr=%b done=%b, required wc=2 cr=1 done=0", wc_a, cr_a, done_a);
    end
  endtask

  task automatic test_end_word;
    send_word_a(32'h0000_0FFF);
    total++;
    if ({done_a, cr_a, err_a} !== 3'b100) begin
      bad++;
      $display("FAIL end_word: got done=%b cr=%b err=%b, required done=1 cr=0 err=0", done_a, cr_a, err_a);
    end
    send_word_a(32'h0102_0304);
    repeat (3) @(negedge clk);
    total++;
    if ({wc_a, done_a, cr_a} !== {13'd2, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL end_ignore: got wc=%0d done=%b cr=%b, required wc=2 done=1 cr=0", wc_a, done_a, cr_a);
    end
  endtask

  task automatic test_start_in_done;
    start_a = 1'b1; byte_a = 8'h55; valid_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; valid_a = 1'b0;
    total++;
    if ({addr_a, wc_a, cr_a, done_a} !== {12'd0, 13'd0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL start_done: got addr=%h wc=%0d cr=%b done=%b, required 0/0/1/0", addr_a, wc_a, cr_a, done_a);
    end
    q_a.push_back('{addr: 12'd0, data: 32'hA5B6_C7D8});
    send_word_a(32'hA5B6_C7D8);
    drain("start_done");
  endtask

  task automatic test_timeout;
    pulse_start_a();
    send_a(8'h11); send_a(8'h22);
    repeat (TO_A) @(negedge clk);
    q_a.push_back('{addr: 12'd0, data: 32'h1122_3344});
    send_word_a(32'h1122_3344);
    drain("timeout");
    // One cycle short of the timeout the partial word must survive
    q_a.push_back('{addr: 12'd1, data: 32'h4433_2211});
    send_a(8'h11); send_a(8'h22);
    repeat (TO_A - 1) @(negedge clk);
    send_a(8'h33); send_a(8'h44);
    drain("timeout_edge");
    total++;
    if (wc_a !== 13'd2) begin
      bad++;
      $display("FAIL timeout_cnt: got wc=%0d, required 2", wc_a);
    end
  endtask

  task automatic test_reset_mid;
    send_a(8'h01); send_a(8'h02);
    rst_n = 1'b0;
    #1;
    total++;
    if ({addr_a, data_a, we_a, cr_a, done_a, err_a, wc_a} !== {12'd0, 32'd0, 4'b0100, 13'd0}) begin
      bad++;
      $display("FAIL rst_async: got addr=%h data=%h we=%b cr=%b done=%b err=%b wc=%0d, required 0/0/0/1/0/0/0",
               addr_a, data_a, we_a, cr_a, done_a, err_a, wc_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    q_a.push_back('{addr: 12'd0, data: 32'hCAFE_F00D});
    send_word_a(32'hCAFE_F00D);
    drain("rst_mid");
  endtask

  task automatic test_full;
    for (int i = 0; i < 4; i++) q_b.push_back('{addr: 12'(i), data: 32'h1000 + i});
    for (int i = 0; i < 4; i++) send_word_b(32'h1000 + i);
    drain("full_fill");
    total++;
    if ({addr_b, wc_b, err_b, done_b} !== {2'd0, 3'd4, 2'b00}) begin
      bad++;
      $display("FAIL full_fill: got addr=%h wc=%0d err=%b done=%b, required addr=0 wc=4 err=0 done=0",
               addr_b, wc_b, err_b, done_b);
    end
    send_word_b(32'h1234_5678);
    repeat (3) @(negedge clk);
    total++;
    if ({err_b, cr_b, done_b, wc_b} !== {3'b110, 3'd4}) begin
      bad++;
      $display("FAIL overflow: got err=%b cr=%b done=%b wc=%0d, required err=1 cr=1 done=0 wc=4",
               err_b, cr_b, done_b, wc_b);
    end
    pulse_start_b();
    total++;
    if ({err_b, cr_b, wc_b, addr_b} !== {2'b01, 3'd0, 2'd0}) begin
      bad++;
      $display("FAIL restart_b: got err=%b cr=%b wc=%0d addr=%h, required err=0 cr=1 wc=0 addr=0",
               err_b, cr_b, wc_b, addr_b);
    end
    for (int i = 0; i < 4; i++) q_b.push_back('{addr: 12'(i), data: 32'h2000 + i});
    for (int i = 0; i < 4; i++) send_word_b(32'h2000 + i);
    drain("full_refill");
    send_word_b(32'h0000_0FFF);
    total++;
    if ({done_b, cr_b, err_b} !== 3'b100) begin
      bad++;
      $display("FAIL full_end: got done=%b cr=%b err=%b, required done=1 cr=0 err=0", done_b, cr_b, err_b);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_end_word();
    test_start_in_done();
    test_timeout();
    test_reset_mid();
    test_full();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
